// File: rtl/rotary_input_conditioner_if.sv
// Pin-side bundle for rotary_input_conditioner: raw encoder/switch pins in, conditioned levels and strobes out.
interface rotary_input_conditioner_if;
    logic rotary_clk_raw;
    logic rotary_dt_raw;
    logic push_raw;
    logic rotary_clk_clean;
    logic rotary_dt_clean;
    logic push_level;
    logic push_pulse;
    logic release_pulse;
    logic long_press_pulse;

    modport master (
        output rotary_clk_raw,
        output rotary_dt_raw,
        output push_raw,
        input  rotary_clk_clean,
        input  rotary_dt_clean,
        input  push_level,
        input  push_pulse,
        input  release_pulse,
        input  long_press_pulse
    );

    modport slave (
        input  rotary_clk_raw,
        input  rotary_dt_raw,
        input  push_raw,
        output rotary_clk_clean,
        output rotary_dt_clean,
        output push_level,
        output push_pulse,
        output release_pulse,
        output long_press_pulse
    );
endinterface

// File: rtl/rotary_input_conditioner.sv
// Synchronises and debounces encoder CLK/DT and the push switch; emits press/release strobes.
// Optional long-press detector is enabled by defining ROTARY_LONG_PRESS_EN.
module rotary_input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 5000,
    parameter int LONG_PRESS_CYCLES = 10000000,
    parameter int PUSH_ACTIVE_LOW   = 1
) (
    input  logic                        clk,
    input  logic                        res,
    rotary_input_conditioner_if.slave   bus
);
    localparam int          CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic        PUSH_INV   = (PUSH_ACTIVE_LOW != 0);
    // Channel order: [0] CLK, [1] DT, [2] push. Push stage idles at its unpressed raw level.
    localparam logic [2:0]  SYNC_RST   = {PUSH_INV, 1'b1, 1'b1};
    localparam logic [2:0]  CLEAN_RST  = 3'b011;

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_clean;
    logic [CW-1:0] r_cnt [3];
    logic          r_push_pulse;
    logic          r_release_pulse;

    logic [2:0]    w_synced;
    logic [2:0]    w_expire;
    logic          w_push_rise;
    logic          w_push_fall;

    always_comb begin
        w_synced = {r_sync2[2] ^ PUSH_INV, r_sync2[1:0]};
        w_expire = '0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            w_expire[ch] = (w_synced[ch] != r_clean[ch]) && (r_cnt[ch] == CNT_LAST);
        end
        w_push_rise = w_expire[2] & w_synced[2];
        w_push_fall = w_expire[2] & ~w_synced[2];
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_sync1         <= SYNC_RST;
            r_sync2         <= SYNC_RST;
            r_clean         <= CLEAN_RST;
            r_push_pulse    <= 1'b0;
            r_release_pulse <= 1'b0;
            for (int unsigned ch = 0; ch < 3; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            r_sync1 <= {bus.push_raw, bus.rotary_dt_raw, bus.rotary_clk_raw};
            r_sync2 <= r_sync1;
            // Any agreement with the clean level restarts the count, so bounces never accumulate.
            for (int unsigned ch = 0; ch < 3; ch++) begin
                if (w_synced[ch] == r_clean[ch]) begin
                    r_cnt[ch] <= '0;
                end else if (w_expire[ch]) begin
                    r_clean[ch] <= w_synced[ch];
                    r_cnt[ch]   <= '0;
                end else begin
                    r_cnt[ch] <= r_cnt[ch] + CW'(1);
                end
            end
            r_push_pulse    <= w_push_rise;
            r_release_pulse <= w_push_fall;
        end
    end

`ifdef ROTARY_LONG_PRESS_EN
    localparam int          HW        = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] r_hold;
    logic          r_long_pulse;

    // Saturating past HOLD_LAST guarantees a single strobe per press.
    always_ff @(posedge clk) begin
        if (res || !r_clean[2]) begin
            r_hold       <= '0;
            r_long_pulse <= 1'b0;
        end else begin
            if (r_hold != HOLD_MAX) begin
                r_hold <= r_hold + HW'(1);
            end
            r_long_pulse <= (r_hold == HOLD_LAST);
        end
    end

    assign bus.long_press_pulse = r_long_pulse;
`else
    assign bus.long_press_pulse = 1'b0;
`endif

    assign bus.rotary_clk_clean = r_clean[0];
    assign bus.rotary_dt_clean  = r_clean[1];
    assign bus.push_level       = r_clean[2];
    assign bus.push_pulse       = r_push_pulse;
    assign bus.release_pulse    = r_release_pulse;
endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Directed self-checking bench for rotary_input_conditioner (DEBOUNCE=4, LONG_PRESS=20, active-low push).
module tb_rotary_input_conditioner;
`ifdef ROTARY_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk;
    logic res;
    int   checks;
    int   failures;

    rotary_input_conditioner_if u_if ();

    rotary_input_conditioner #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20),
        .PUSH_ACTIVE_LOW   (1)
    ) u_dut (
        .clk (clk),
        .res (res),
        .bus (u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed outputs packed as {clk_clean, dt_clean, push_level, push_pulse, release_pulse, long_press_pulse}
    function automatic logic [5:0] outs();
        return {u_if.rotary_clk_clean, u_if.rotary_dt_clean, u_if.push_level,
                u_if.push_pulse, u_if.release_pulse, u_if.long_press_pulse};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        res = 1'b1;
        u_if.rotary_clk_raw = 1'b1;
        u_if.rotary_dt_raw  = 1'b1;
        u_if.push_raw       = 1'b1;
        repeat (3) tick();
        obs = outs();
        checks++;
        if (obs !== 6'b110000) begin
            failures++;
            $display("FAIL reset got=%b exp=%b", obs, 6'b110000);
        end
        res = 1'b0;
        tick();
        obs = outs();
        checks++;
        if (obs !== 6'b110000) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs, 6'b110000);
        end
    endtask

    task automatic test_clean_step();
        logic [5:0] obs;
        logic [5:0] exp;
        u_if.rotary_clk_raw = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            obs = outs();
            exp = {(t >= 6) ? 1'b0 : 1'b1, 1'b1, 4'b0000};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL clean_step_fall t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
        u_if.rotary_clk_raw = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            obs = outs();
            exp = {(t >= 6) ? 1'b1 : 1'b0, 1'b1, 4'b0000};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL clean_step_rise t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] obs;
        logic [5:0] exp;
        u_if.rotary_clk_raw = 1'b0;
        u_if.rotary_dt_raw  = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            obs = outs();
            exp = (t >= 6) ? 6'b000000 : 6'b110000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL simultaneous_fall t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
        u_if.rotary_clk_raw = 1'b1;
        u_if.rotary_dt_raw  = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            obs = outs();
            exp = (t >= 6) ? 6'b110000 : 6'b000000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL simultaneous_rise t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] obs;
        logic [5:0] exp;
        // Raw push: low 2, high 2, then held low from tick 5; final fall settles at tick 10.
        for (int t = 1; t <= 14; t++) begin
            u_if.push_raw = (t == 3 || t == 4) ? 1'b1 : 1'b0;
            tick();
            obs = outs();
            exp = {2'b11, (t >= 10), (t == 10), 2'b00};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bounce t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
        u_if.push_raw = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            obs = outs();
            exp = {2'b11, (t < 6), 1'b0, (t == 6), 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bounce_release t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [5:0] obs;
        for (int t = 1; t <= 12; t++) begin
            u_if.rotary_dt_raw = (t <= 3) ? 1'b0 : 1'b1;
            tick();
            obs = outs();
            checks++;
            if (obs !== 6'b110000) begin
                failures++;
                $display("FAIL glitch t=%0d got=%b exp=%b", t, obs, 6'b110000);
            end
        end
    endtask

    task automatic test_long_press();
        logic [5:0] obs;
        logic [5:0] exp;
        // Press for 30 ticks then release: level 6..35, long strobe 20 after level rises.
        for (int t = 1; t <= 40; t++) begin
            u_if.push_raw = (t <= 30) ? 1'b0 : 1'b1;
            tick();
            obs = outs();
            exp = {2'b11, (t >= 6 && t < 36), (t == 6), (t == 36), (LP_EN && t == 26)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL long_press t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs;
        logic [5:0] exp;
        u_if.push_raw = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            tick();
            obs = outs();
            checks++;
            if (obs !== 6'b110000) begin
                failures++;
                $display("FAIL reset_mid_pre t=%0d got=%b exp=%b", t, obs, 6'b110000);
            end
        end
        res = 1'b1;
        tick();
        res = 1'b0;
        obs = outs();
        checks++;
        if (obs !== 6'b110000) begin
            failures++;
            $display("FAIL reset_mid_during got=%b exp=%b", obs, 6'b110000);
        end
        for (int t = 1; t <= 9; t++) begin
            tick();
            obs = outs();
            exp = {2'b11, (t >= 6), (t == 6), 2'b00};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_mid_after t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
        u_if.push_raw = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            obs = outs();
            exp = {2'b11, (t < 6), 1'b0, (t == 6), 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_mid_release t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        res      = 1'b1;
        u_if.rotary_clk_raw = 1'b1;
        u_if.rotary_dt_raw  = 1'b1;
        u_if.push_raw       = 1'b1;
        test_reset();
        test_clean_step();
        test_simultaneous();
        test_bounce();
        test_glitch();
        test_long_press();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
